sipo_deser: RTL and testbench

Serial-in parallel-out deserializer. It is the receive-side counterpart of the team's parallel-register path. It collects a bit stream under a valid/ready handshake, assembles WIDTH-bit words, and presents each word on a parallel valid/ready output with one word of buffering. It sits between a serial link front-end and any word-wide consumer (register file, FIFO).

---
 rtl/sipo_deser_pkg.sv | 15 +
 rtl/sipo_deser.sv | 128 ++++++++++++
 tb/tb_sipo_deser.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sipo_deser_pkg.sv
// Shared definitions for the sipo_deser serial-in parallel-out deserializer:
// FSM state encoding and bit-counter sizing.
package sipo_deser_pkg;

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_e;

    // Wide enough for 0..WIDTH, which covers the extra parity-bit slot.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/sipo_deser.sv
// Serial-in parallel-out deserializer with a one-word output slot and a hold stage.
// Define SIPO_DESER_PARITY_EN to expect an even-parity bit after each word and to add the parity_err output.
//
// state   | meaning
// --------+------------------------------------------------------------
// COLLECT | accepting serial bits (ser_ready=1)
// HOLD    | full word parked in the shift register while par_out is busy
module sipo_deser
    import sipo_deser_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ser_in,
    input  logic             ser_valid,
    output logic             ser_ready,
    output logic [WIDTH-1:0] par_out,
    output logic             par_valid,
    input  logic             par_ready
`ifdef SIPO_DESER_PARITY_EN
    ,
    output logic             parity_err
`endif
);

    localparam int CW = cnt_width(WIDTH);
`ifdef SIPO_DESER_PARITY_EN
    localparam int LAST_INT = WIDTH;
`else
    localparam int LAST_INT = WIDTH - 1;
`endif
    localparam logic [CW-1:0] CNT_LAST  = CW'(LAST_INT);
    localparam logic [0:0]    S_COLLECT = COLLECT;
    localparam logic [0:0]    S_HOLD    = HOLD;

    logic [0:0]       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] shift_q;
    logic [WIDTH-1:0] shift_nxt;
    logic             bit_acc;
    logic             data_bit;
    logic             word_done;
    logic             xfer;
    logic             slot_free;
    logic             in_collect;
    logic             load_now;
    logic             hold_now;
    logic             drain_now;

    assign bit_acc    = ser_valid & ser_ready;
    assign xfer       = par_valid & par_ready;
    assign slot_free  = ~par_valid | xfer;
    assign in_collect = (state == S_COLLECT);
    assign word_done  = bit_acc & (cnt == CNT_LAST);
    assign load_now   = in_collect & word_done & slot_free;
    assign hold_now   = in_collect & word_done & ~slot_free;
    assign drain_now  = ~in_collect & xfer;

    // The parity slot sits one past the last data bit and never enters the word.
`ifdef SIPO_DESER_PARITY_EN
    assign data_bit = (cnt != CW'(WIDTH));
`else
    assign data_bit = 1'b1;
`endif

    always_comb begin
        shift_nxt = shift_q;
        if (bit_acc && data_bit) begin
            if (MSB_FIRST) shift_nxt = {shift_q[WIDTH-2:0], ser_in};
            else           shift_nxt = {ser_in, shift_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_COLLECT;
            cnt       <= '0;
            shift_q   <= '0;
            par_out   <= '0;
            par_valid <= 1'b0;
            ser_ready <= 1'b1;
        end else begin
            if (bit_acc) begin
                shift_q <= shift_nxt;
                cnt     <= word_done ? '0 : cnt + CW'(1);
            end

            if (load_now) begin
                par_out   <= shift_nxt;
                par_valid <= 1'b1;
            end else if (drain_now) begin
                par_out   <= shift_q;
            end else if (xfer) begin
                par_valid <= 1'b0;
            end

            if (hold_now) begin
                state     <= S_HOLD;
                ser_ready <= 1'b0;
            end else if (drain_now) begin
                state     <= S_COLLECT;
                ser_ready <= 1'b1;
            end
        end
    end

`ifdef SIPO_DESER_PARITY_EN
    logic word_par;
    logic perr_hold;

    assign word_par = (^shift_nxt) ^ ser_in;

    // A parked word keeps its parity result until it moves into par_out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parity_err <= 1'b0;
            perr_hold  <= 1'b0;
        end else begin
            if (load_now)       parity_err <= word_par;
            else if (drain_now) parity_err <= perr_hold;
            if (hold_now)       perr_hold  <= word_par;
        end
    end
`endif

endmodule

// File: tb/tb_sipo_deser.sv
// Scoreboard bench for sipo_deser: two instances (MSB-first and LSB-first) share one stimulus stream.
// Build with SIPO_DESER_PARITY_EN defined to exercise the parity bit and parity_err.
module tb_sipo_deser;

    localparam int WIDTH = 4;
`ifdef SIPO_DESER_PARITY_EN
    localparam int NBITS = WIDTH + 1;
    localparam bit PAR   = 1'b1;
`else
    localparam int NBITS = WIDTH;
    localparam bit PAR   = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             ser_in = 1'b0;
    logic             ser_valid = 1'b0;
    logic             par_ready = 1'b0;
    logic             ser_ready_m, ser_ready_l;
    logic             par_valid_m, par_valid_l;
    logic [WIDTH-1:0] par_out_m, par_out_l;
    logic             perr_m, perr_l;

    typedef struct packed {
        logic [WIDTH-1:0] m;
        logic [WIDTH-1:0] l;
        logic             perr;
    } exp_t;

    exp_t exp_q[$];
    bit   acc_bits[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;
    bit   rand_ready = 1'b0;

    sipo_deser #(.WIDTH(WIDTH), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .rst(rst), .ser_in(ser_in), .ser_valid(ser_valid),
        .ser_ready(ser_ready_m), .par_out(par_out_m), .par_valid(par_valid_m),
        .par_ready(par_ready)
`ifdef SIPO_DESER_PARITY_EN
        , .parity_err(perr_m)
`endif
    );

    sipo_deser #(.WIDTH(WIDTH), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .rst(rst), .ser_in(ser_in), .ser_valid(ser_valid),
        .ser_ready(ser_ready_l), .par_out(par_out_l), .par_valid(par_valid_l),
        .par_ready(par_ready)
`ifdef SIPO_DESER_PARITY_EN
        , .parity_err(perr_l)
`endif
    );

`ifndef SIPO_DESER_PARITY_EN
    assign perr_m = 1'b0;
    assign perr_l = 1'b0;
`endif

    always #5 clk = ~clk;

    // Monitor / reference model: words are built from accepted bits by plain
    // arithmetic; queue depth gives the expected valid/ready handshake state.
    always @(negedge clk) begin
        if (rst) begin
            checks++;
            if (ser_ready_m !== 1'b1 || ser_ready_l !== 1'b1 || par_valid_m !== 1'b0 ||
                par_valid_l !== 1'b0 || par_out_m !== '0 || par_out_l !== '0 ||
                perr_m !== 1'b0 || perr_l !== 1'b0) begin
                errors++;
                $display("FAIL reset_values: ready=%b/%b valid=%b/%b out=%h/%h perr=%b/%b required ready=1 valid=0 out=0 perr=0",
                         ser_ready_m, ser_ready_l, par_valid_m, par_valid_l, par_out_m, par_out_l, perr_m, perr_l);
            end
            acc_bits.delete();
            exp_q.delete();
        end else begin
            checks++;
            if (ser_ready_m !== (exp_q.size() < 2) || ser_ready_l !== (exp_q.size() < 2)) begin
                errors++;
                $display("FAIL ser_ready: got %b/%b required %b (t=%0t)",
                         ser_ready_m, ser_ready_l, exp_q.size() < 2, $time);
            end
            checks++;
            if (par_valid_m !== (exp_q.size() > 0) || par_valid_l !== (exp_q.size() > 0)) begin
                errors++;
                $display("FAIL par_valid: got %b/%b required %b (t=%0t)",
                         par_valid_m, par_valid_l, exp_q.size() > 0, $time);
            end
            if (exp_q.size() > 0) begin
                checks++;
                if (par_out_m !== exp_q[0].m || par_out_l !== exp_q[0].l ||
                    perr_m !== exp_q[0].perr || perr_l !== exp_q[0].perr) begin
                    errors++;
                    $display("FAIL word: got out=%h/%h perr=%b/%b required out=%h/%h perr=%b (t=%0t)",
                             par_out_m, par_out_l, perr_m, perr_l,
                             exp_q[0].m, exp_q[0].l, exp_q[0].perr, $time);
                end
                if (par_ready) void'(exp_q.pop_front());
            end
            if (ser_valid && ser_ready_m) begin
                acc_bits.push_back(ser_in);
                if (acc_bits.size() == NBITS) begin
                    e = '0;
                    for (int i = 0; i < WIDTH; i++) begin
                        e.m    = (e.m << 1) | WIDTH'(acc_bits[i]);
                        e.l[i] = acc_bits[i];
                    end
                    for (int i = 0; i < NBITS; i++) e.perr = e.perr ^ acc_bits[i];
                    e.perr = e.perr & PAR;
                    exp_q.push_back(e);
                    acc_bits.delete();
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (rand_ready) par_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic send_bit(input logic b);
        int  waited;
        logic rdy;
        waited    = 0;
        ser_valid = 1'b1;
        ser_in    = b;
        forever begin
            rdy = ser_ready_m;
            step();
            if (rdy) break;
            waited++;
            if (waited > 300) begin
                checks++;
                errors++;
                $display("FAIL bit_accept_timeout: ser_ready low for %0d cycles required accept within 300", waited);
                break;
            end
        end
        ser_valid = 1'b0;
    endtask

    // Bits go out w[WIDTH-1] first; pbit follows only in the parity build.
    task automatic send_word(input logic [WIDTH-1:0] w, input bit gaps, input logic pbit);
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (gaps) begin
                repeat ($urandom_range(0, 3)) begin
                    ser_in = 1'($urandom);
                    step();
                end
            end
            send_bit(w[i]);
        end
`ifdef SIPO_DESER_PARITY_EN
        send_bit(pbit);
`else
        if (pbit === 1'bx) ser_in = 1'b0;
`endif
    endtask

    task automatic check_out(input string name, input logic [WIDTH-1:0] em, input logic [WIDTH-1:0] el,
                             input logic ep, input logic ev, input logic er);
        checks++;
        if (par_out_m !== em || par_out_l !== el || perr_m !== ep || par_valid_m !== ev || ser_ready_m !== er) begin
            errors++;
            $display("FAIL %s: got out=%h/%h perr=%b valid=%b ready=%b required out=%h/%h perr=%b valid=%b ready=%b",
                     name, par_out_m, par_out_l, perr_m, par_valid_m, ser_ready_m, em, el, ep, ev, er);
        end
    endtask

    task automatic pulse_reset();
        #2 rst = 1'b1;
        idle(2);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle(3);
        rst = 1'b0;

        // Directed word, both shift orders, valid for exactly one cycle.
        par_ready = 1'b1;
        send_word(4'b1011, 1'b0, 1'b1);
        @(negedge clk);
        check_out("direct_1011", 4'b1011, 4'b1101, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        checks++;
        if (par_valid_m !== 1'b0) begin
            errors++;
            $display("FAIL valid_drop: got %b required 0", par_valid_m);
        end
        step();

        // Same word with the wrong parity bit.
        send_word(4'b1011, 1'b0, 1'b0);
        @(negedge clk);
        check_out("direct_bad_parity", 4'b1011, 4'b1101, PAR, 1'b1, 1'b1);
        step();
        idle(2);

        // Back-to-back words with the consumer stalled.
        par_ready = 1'b0;
        send_word(4'hA, 1'b0, 1'b0);
        send_word(4'h5, 1'b0, 1'b0);
        @(negedge clk);
        check_out("hold_full", 4'hA, 4'h5, 1'b0, 1'b1, 1'b0);
        step();
        par_ready = 1'b1;
        idle(3);
        check_out("hold_drained", 4'h5, 4'hA, 1'b0, 1'b0, 1'b1);

        // Random serial gaps, consumer always ready.
        for (int k = 0; k < 3; k++) send_word(WIDTH'($urandom), 1'b1, 1'($urandom));
        idle(3);

        // Random gaps and random backpressure.
        rand_ready = 1'b1;
        for (int k = 0; k < 12; k++) send_word(WIDTH'($urandom), 1'b1, 1'($urandom));
        rand_ready = 1'b0;
        par_ready  = 1'b1;
        idle(4);

        // Reset mid-word: the partial word is discarded.
        send_bit(1'b1);
        send_bit(1'b0);
        pulse_reset();
        send_word(4'h6, 1'b0, 1'b0);
        idle(3);

        // Reset in HOLD: both buffered words are discarded.
        par_ready = 1'b0;
        send_word(4'h3, 1'b0, 1'b0);
        send_word(4'hC, 1'b0, 1'b0);
        pulse_reset();
        par_ready = 1'b1;
        send_word(4'h6, 1'b0, 1'b0);
        @(negedge clk);
        check_out("after_reset_6", 4'h6, 4'h6, 1'b0, 1'b1, 1'b1);
        step();
        idle(4);

        checks++;
        if (exp_q.size() != 0 || acc_bits.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d words and %0d bits left in model, required 0 and 0",
                     exp_q.size(), acc_bits.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
